// File: rtl/btb_pkg.sv
// Shared types and helpers for the set-associative BTB:
// counter type and saturating step, PC index/tag slicing.
package btb_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SN = 2'b00;
  localparam ctr_t CTR_WN = 2'b01;
  localparam ctr_t CTR_WT = 2'b10;
  localparam ctr_t CTR_ST = 2'b11;

  function automatic ctr_t ctr_next(ctr_t c, logic taken);
    ctr_t r;
    r = c;
    if (taken) begin
      if (c != CTR_ST) r = ctr_t'(c + 2'b01);
    end else begin
      if (c != CTR_SN) r = ctr_t'(c - 2'b01);
    end
    return r;
  endfunction

  // Set index: pc[idx_w+1:2]; zero when idx_w==0.
  function automatic logic [31:0] pc_idx(
    logic [31:0] pc, int idx_w
  );
    return (pc >> 2) & ((32'h1 << idx_w) - 32'h1);
  endfunction

  // Tag: pc[idx_w+tag_w+1:idx_w+2].
  function automatic logic [31:0] pc_tag(
    logic [31:0] pc, int idx_w, int tag_w
  );
    return (pc >> (idx_w + 2)) &
           ((32'h1 << tag_w) - 32'h1);
  endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// Fetch lookup / execute update bus of the BTB.
// Ports: en, flush, pc, hit, prediction, target,
// upd_valid/pc/target/taken/mispred, optional stat_* (BTB_STATS_EN).
interface btb_assoc_if;
  logic        en;
  logic        flush;
  logic [31:0] pc;
  logic        hit;
  logic        prediction;
  logic [31:0] target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_mispred;
`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_hits;
  logic [31:0] stat_mispred;

  modport master (
    output en, flush, pc,
    output upd_valid, upd_pc, upd_target,
    output upd_taken, upd_mispred,
    input  hit, prediction, target,
    input  stat_lookups, stat_hits, stat_mispred
  );
  modport slave (
    input  en, flush, pc,
    input  upd_valid, upd_pc, upd_target,
    input  upd_taken, upd_mispred,
    output hit, prediction, target,
    output stat_lookups, stat_hits, stat_mispred
  );
`else
  modport master (
    output en, flush, pc,
    output upd_valid, upd_pc, upd_target,
    output upd_taken, upd_mispred,
    input  hit, prediction, target
  );
  modport slave (
    input  en, flush, pc,
    input  upd_valid, upd_pc, upd_target,
    input  upd_taken, upd_mispred,
    output hit, prediction, target
  );
`endif
endinterface

// File: rtl/btb_set.sv
// One BTB set: WAYS entries, tag compare, victim select, rr pointer.
// Ports: clk, reset, flush_i, lk_* lookup, upd_* write (pre-decoded).
module btb_set
  import btb_pkg::*;
#(
  parameter int   WAYS     = 2,
  parameter int   TAG_W    = 10,
  parameter ctr_t CTR_INIT = CTR_WT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic [TAG_W-1:0] lk_tag_i,
  output logic             lk_hit_o,
  output logic             lk_taken_o,
  output logic [31:0]      lk_target_o,
  input  logic             upd_we_i,
  input  logic [TAG_W-1:0] upd_tag_i,
  input  logic [31:0]      upd_target_i,
  input  logic             upd_taken_i
);

  localparam int RR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [WAYS];
  logic [TAG_W-1:0] tag_d [WAYS];
  logic [31:0]      tgt_q [WAYS];
  logic [31:0]      tgt_d [WAYS];
  ctr_t             ctr_q [WAYS];
  ctr_t             ctr_d [WAYS];
  logic [RR_W-1:0]  rr_q, rr_d;

  logic upd_hit;
  logic has_inv;
  int   hit_w;
  int   vic_w;

  // Descending scan so the lowest matching way wins.
  always_comb begin
    lk_hit_o    = 1'b0;
    lk_taken_o  = 1'b0;
    lk_target_o = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w] && tag_q[w] == lk_tag_i) begin
        lk_hit_o    = 1'b1;
        lk_taken_o  = ctr_q[w][1];
        lk_target_o = tgt_q[w];
      end
    end
  end

  always_comb begin
    upd_hit = 1'b0;
    hit_w   = 0;
    has_inv = 1'b0;
    vic_w   = int'(rr_q);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w] && tag_q[w] == upd_tag_i) begin
        upd_hit = 1'b1;
        hit_w   = w;
      end
      if (!valid_q[w]) begin
        has_inv = 1'b1;
        vic_w   = w;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    rr_d    = rr_q;
    if (flush_i) begin
      valid_d = '0;
      rr_d    = '0;
    end else if (upd_we_i) begin
      if (upd_hit) begin
        for (int w = 0; w < WAYS; w++) begin
          if (w == hit_w) begin
            ctr_d[w] = ctr_next(ctr_q[w], upd_taken_i);
            if (upd_taken_i) tgt_d[w] = upd_target_i;
          end
        end
      end else if (upd_taken_i) begin
        for (int w = 0; w < WAYS; w++) begin
          if (w == vic_w) begin
            valid_d[w] = 1'b1;
            tag_d[w]   = upd_tag_i;
            tgt_d[w]   = upd_target_i;
            ctr_d[w]   = CTR_INIT;
          end
        end
        // rr only moves when it actually picked the victim.
        if (!has_inv) begin
          rr_d = (WAYS == 1) ? '0 : rr_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      rr_q    <= '0;
      for (int w = 0; w < WAYS; w++) begin
        tag_q[w] <= '0;
        tgt_q[w] <= '0;
        ctr_q[w] <= CTR_WN;
      end
    end else begin
      valid_q <= valid_d;
      rr_q    <= rr_d;
      for (int w = 0; w < WAYS; w++) begin
        tag_q[w] <= tag_d[w];
        tgt_q[w] <= tgt_d[w];
        ctr_q[w] <= ctr_d[w];
      end
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB top: index decode, set array, output mux.
// Ports: clk, reset, bus (btb_assoc_if.slave). Option: BTB_STATS_EN.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int   ENTRIES  = 64,
  parameter int   WAYS     = 2,
  parameter int   TAG_W    = 10,
  parameter ctr_t CTR_INIT = CTR_WT
) (
  input logic        clk,
  input logic        reset,
  btb_assoc_if.slave bus
);

  localparam int SETS  = ENTRIES / WAYS;
  localparam int IDX_W = $clog2(SETS);
  localparam int IW    = (IDX_W > 0) ? IDX_W : 1;

  if (!(WAYS == 1 || WAYS == 2 || WAYS == 4)) begin : g_bad_ways
    $error("btb_assoc: WAYS must be 1, 2 or 4");
  end
  if ((ENTRIES & (ENTRIES - 1)) != 0 || ENTRIES < WAYS)
  begin : g_bad_entries
    $error("btb_assoc: ENTRIES must be a power of two >= WAYS");
  end
  if (IDX_W + 2 + TAG_W > 32) begin : g_bad_tag
    $error("btb_assoc: tag slice exceeds bit 31");
  end

  logic [IW-1:0]    lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;

  assign lk_idx = IW'(pc_idx(bus.pc, IDX_W));
  assign lk_tag = TAG_W'(pc_tag(bus.pc, IDX_W, TAG_W));
  assign up_idx = IW'(pc_idx(bus.upd_pc, IDX_W));
  assign up_tag = TAG_W'(pc_tag(bus.upd_pc, IDX_W, TAG_W));

  logic        set_hit [SETS];
  logic        set_tk  [SETS];
  logic [31:0] set_tgt [SETS];

  for (genvar s = 0; s < SETS; s++) begin : g_set
    btb_set #(
      .WAYS     (WAYS),
      .TAG_W    (TAG_W),
      .CTR_INIT (CTR_INIT)
    ) u_set (
      .clk          (clk),
      .reset        (reset),
      .flush_i      (bus.flush),
      .lk_tag_i     (lk_tag),
      .lk_hit_o     (set_hit[s]),
      .lk_taken_o   (set_tk[s]),
      .lk_target_o  (set_tgt[s]),
      .upd_we_i     (bus.upd_valid && up_idx == IW'(s)),
      .upd_tag_i    (up_tag),
      .upd_target_i (bus.upd_target),
      .upd_taken_i  (bus.upd_taken)
    );
  end

  logic lk_hit;

  assign lk_hit         = bus.en & set_hit[lk_idx];
  assign bus.hit        = lk_hit;
  assign bus.prediction = lk_hit & set_tk[lk_idx];
  assign bus.target     = lk_hit ? set_tgt[lk_idx] : '0;

`ifdef BTB_STATS_EN
  logic [31:0] lookups_q, hits_q, mispred_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lookups_q <= '0;
      hits_q    <= '0;
      mispred_q <= '0;
    end else begin
      if (bus.en) lookups_q <= lookups_q + 32'd1;
      if (lk_hit) hits_q    <= hits_q + 32'd1;
      if (bus.upd_valid && bus.upd_mispred)
        mispred_q <= mispred_q + 32'd1;
    end
  end

  assign bus.stat_lookups = lookups_q;
  assign bus.stat_hits    = hits_q;
  assign bus.stat_mispred = mispred_q;
`else
  logic unused_mispred;
  assign unused_mispred = bus.upd_mispred;
`endif

endmodule

// File: tb/tb_btb_assoc.sv
// Directed self-checking bench for btb_assoc (2-way, 32 sets).
// Expected lookups are queued at drive time and popped at check.
module tb_btb_assoc;

  logic clk;
  logic reset;

  btb_assoc_if bus ();

  btb_assoc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        hit;
    logic        pred;
    logic [31:0] tgt;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] e);
    n_assert++;
    assert (got === e) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", nm, got, e);
    end
  endtask

  // Drive a lookup, queue its expectation, check after settling.
  task automatic lookup(string nm, logic [31:0] p,
                        logic eh, logic ep, logic [31:0] et);
    exp_t e;
    bus.en = 1'b1;
    bus.pc = p;
    e.nm = nm; e.hit = eh; e.pred = ep; e.tgt = et;
    exp_q.push_back(e);
    #1;
    e = exp_q.pop_front();
    chk({e.nm, ".hit"},  {31'd0, bus.hit},        {31'd0, e.hit});
    chk({e.nm, ".pred"}, {31'd0, bus.prediction}, {31'd0, e.pred});
    chk({e.nm, ".tgt"},  bus.target,              e.tgt);
  endtask

  task automatic upd(logic [31:0] p, logic [31:0] t, logic tk,
                     logic mp = 1'b0, logic fl = 1'b0);
    bus.upd_valid   = 1'b1;
    bus.upd_pc      = p;
    bus.upd_target  = t;
    bus.upd_taken   = tk;
    bus.upd_mispred = mp;
    bus.flush       = fl;
    @(posedge clk);
    #1;
    bus.upd_valid   = 1'b0;
    bus.upd_mispred = 1'b0;
    bus.flush       = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.en          = 1'b1;
    bus.flush       = 1'b0;
    bus.pc          = 32'h100;
    bus.upd_valid   = 1'b0;
    bus.upd_pc      = '0;
    bus.upd_target  = '0;
    bus.upd_taken   = 1'b0;
    bus.upd_mispred = 1'b0;
    #1;
    lookup("in_reset", 32'h100, 0, 0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    lookup("post_reset", 32'h100, 0, 0, 32'h0);

    // Allocation with weakly-taken init
    upd(32'h100, 32'h400, 1);
    lookup("alloc", 32'h100, 1, 1, 32'h400);

    // Counter down-steps, not-taken keeps target
    upd(32'h100, 32'h999, 0);
    lookup("nt1", 32'h100, 1, 0, 32'h400);
    upd(32'h100, 32'h999, 0);
    lookup("nt2", 32'h100, 1, 0, 32'h400);
    upd(32'h100, 32'h999, 0);
    upd(32'h100, 32'h404, 1);
    lookup("sat_lo", 32'h100, 1, 0, 32'h404);
    upd(32'h100, 32'h404, 1);
    lookup("wt", 32'h100, 1, 1, 32'h404);
    upd(32'h100, 32'h404, 1);
    upd(32'h100, 32'h404, 1);
    upd(32'h100, 32'h404, 0);
    lookup("sat_hi", 32'h100, 1, 1, 32'h404);

    // Aliasing in set 0; rr=0 victim then rr=1
    upd(32'h200, 32'h2000, 1);
    upd(32'h300, 32'h3000, 1);
    lookup("evict_100", 32'h100, 0, 0, 32'h0);
    lookup("keep_200",  32'h200, 1, 1, 32'h2000);
    lookup("new_300",   32'h300, 1, 1, 32'h3000);
    upd(32'h100, 32'h1111, 0);
    lookup("nt_noalloc", 32'h100, 0, 0, 32'h0);
    lookup("nt_keep200", 32'h200, 1, 1, 32'h2000);
    upd(32'h400, 32'h4000, 1);
    lookup("rr1_200", 32'h200, 0, 0, 32'h0);
    lookup("rr1_300", 32'h300, 1, 1, 32'h3000);
    lookup("rr1_400", 32'h400, 1, 1, 32'h4000);

    // Another set is independent
    upd(32'h104, 32'h5104, 1);
    lookup("set1", 32'h104, 1, 1, 32'h5104);
    lookup("set0_ok", 32'h400, 1, 1, 32'h4000);

    // Flush wins over concurrent update
    upd(32'h500, 32'h5000, 1, 0, 1);
    lookup("fl_500", 32'h500, 0, 0, 32'h0);
    lookup("fl_300", 32'h300, 0, 0, 32'h0);
    lookup("fl_104", 32'h104, 0, 0, 32'h0);

    // rr cleared by flush: 3rd alloc evicts way 0
    upd(32'h300, 32'h3300, 1);
    upd(32'h100, 32'h1100, 1);
    upd(32'h200, 32'h2200, 1);
    lookup("rr0_300", 32'h300, 0, 0, 32'h0);
    lookup("rr0_100", 32'h100, 1, 1, 32'h1100);
    lookup("rr0_200", 32'h200, 1, 1, 32'h2200);

    // en=0 gates outputs
    bus.en = 1'b0;
    bus.pc = 32'h100;
    #1;
    chk("en0.hit",  {31'd0, bus.hit},        32'd0);
    chk("en0.pred", {31'd0, bus.prediction}, 32'd0);
    chk("en0.tgt",  bus.target,              32'd0);

    // Reset across an update edge aborts the write
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = 32'h700;
    bus.upd_target = 32'h7000;
    bus.upd_taken  = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    lookup("rst_mid", 32'h100, 0, 0, 32'h0);
    @(posedge clk); #1;
    bus.upd_valid = 1'b0;
    reset = 1'b0;
    lookup("rst_700", 32'h700, 0, 0, 32'h0);
    lookup("rst_100", 32'h100, 0, 0, 32'h0);

`ifdef BTB_STATS_EN
    bus.en = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    upd(32'h100, 32'h1000, 1, 1);
    upd(32'h200, 32'h2000, 1, 1);
    bus.en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.pc = (i < 4) ? 32'h100 : 32'h800;
      @(posedge clk); #1;
    end
    bus.en = 1'b0;
    upd(32'h900, 32'h0, 0, 0, 1);
    chk("st.lookups", bus.stat_lookups, 32'd10);
    chk("st.hits",    bus.stat_hits,    32'd4);
    chk("st.mispred", bus.stat_mispred, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
- Parametrised, set-associative branch target buffer for the fetch stage.
- Each entry holds a tagged target and a 2-bit saturating direction counter.
- Replaces the direct-mapped, 1-bit, untagged predictor.
- Lookup is combinational on the fetch PC; resolved-branch updates from execute are written at the clock edge.

Parameters:
- ENTRIES, 64, total entries; power of two, ≥ WAYS.
- WAYS, 2, associativity; legal values 1, 2, 4.
- TAG_W, 10, stored tag bits; must satisfy log2(ENTRIES/WAYS)+2+TAG_W ≤ 32.
- CTR_INIT, 2'b10, counter value written on allocation (weakly taken).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  lookup enable (fetch valid)
- flush  in  1  synchronous invalidate-all
- pc  in  32  fetch PC for lookup
- hit  out  1  tag match in the indexed set
- prediction  out  1  predicted taken
- target  out  32  predicted target
- upd_valid  in  1  resolved-branch update strobe
- upd_pc  in  32  PC of the resolved branch
- upd_target  in  32  computed branch target
- upd_taken  in  1  actual branch outcome
- upd_mispred  in  1  execute flagged a misprediction; used only by the stats feature
- stat_lookups, stat_hits, stat_mispred  out  32 each  present only with BTB_STATS_EN

Behaviour:
- Geometry: SETS=ENTRIES/WAYS, IDX_W=log2(SETS).
  - index = pc[IDX_W+1:2]
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2]
  - The update path uses the same slicing on upd_pc.
- Storage per way: valid, tag, target[31:0], ctr[1:0]. Per set: round-robin victim pointer rr (log2(WAYS) bits; absent when WAYS=1).
- Lookup, combinational, 0-cycle latency:
  - hit = en & any way has (valid & tag match). If several ways match, the lowest-numbered way wins.
  - prediction = hit & ctr[1].
  - target = matching way's target when hit, else 32'h0.
  - en=0 forces hit=0, prediction=0, target=0.
- Lookup never modifies state.
- Update on posedge clk when upd_valid=1 and flush=0:
  - Hit in the update set: ctr saturates +1 if upd_taken, −1 if not (00 ↔ 11 saturation). target is overwritten with upd_target only when upd_taken=1. rr is unchanged.
  - Miss with upd_taken=1: allocate a victim way.
    - Victim is the lowest-numbered invalid way; if every way is valid, the victim is rr.
    - Write valid=1, tag, target=upd_target, ctr=CTR_INIT.
    - rr advances by 1 (mod WAYS) only when rr was used as the victim.
  - Miss with upd_taken=0: no change, so not-taken branches do not pollute the table.
- Read/write in the same cycle with the same set: the lookup returns the pre-update contents; there is no bypass.
- flush=1: all valid bits clear at the edge and all rr pointers reset to 0. flush takes priority over a concurrent update, which is dropped. Counters and targets are left untouched.
- Reset (async): all valid=0, ctr=2'b01, rr=0. Targets and tags are don't-care.
  - Outputs during and after reset: hit=0, prediction=0, target=0.
  - Reset asserted mid-update aborts that write.
- Elaboration error if WAYS∉{1,2,4}, ENTRIES is not a power of two, or the tag slice exceeds bit 31.

Optional Feature:
- Macro: BTB_STATS_EN.
- Defined:
  - Three 32-bit wrapping counters, cleared by reset only (not by flush).
  - stat_lookups increments on each cycle with en=1.
  - stat_hits increments on each cycle with en&hit.
  - stat_mispred increments on upd_valid&upd_mispred.
- Undefined: the stat ports and counters are absent. Table behaviour is identical in both builds.

Decomposition:
- Package btb_pkg holds:
  - ctr_t (2-bit) and the constants CTR_SN=00, CTR_WN=01, CTR_WT=10, CTR_ST=11.
  - The function ctr_next(ctr_t, taken) implementing the saturating step.
  - The index/tag slicing functions, parametrised by IDX_W/TAG_W.
- Sub-module btb_set: one set's ways, tag compare, victim select and rr pointer. It is instantiated SETS times by generate; btb_assoc does index decode and output muxing.

Test Plan:
- Reset, then en=1, pc=0x100 -> hit=0, prediction=0, target=0.
- Update upd_pc=0x100, upd_target=0x400, upd_taken=1; next cycle lookup pc=0x100 -> hit=1, prediction=1 (ctr=10), target=0x400.
- Two not-taken updates on 0x100 -> ctr 10→01→00, prediction=0, hit=1. One taken update -> ctr=01, prediction=0.
- Aliasing, WAYS=2, SETS=32: allocate taken branches at 0x100, 0x200, 0x300 (same index, different tags).
  - 0x300 evicts the way holding 0x100 (rr=0).
  - Result: lookup 0x100 misses; 0x200 and 0x300 hit.
  - Same pattern with upd_taken=0 on a miss -> no allocation.
- flush asserted in the same cycle as an update of 0x500 -> all entries miss afterwards; 0x500 is not allocated.
- BTB_STATS_EN build: 10 cycles of en=1 with 4 hits and 2 updates carrying upd_mispred=1 -> stat_lookups=10, stat_hits=4, stat_mispred=2. A flush leaves the counters unchanged.
